// File: rtl/alu_protocol_monitor.sv
// Passive protocol monitor for the ALU.
// Checks operand pairing/timeout, expected ERR, output hold while disabled, and G/L/E exclusivity.
module alu_protocol_monitor #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int LATENCY   = 1,
  parameter int TIMEOUT   = 16,
  parameter logic [(1<<CMD_WIDTH)-1:0] ARITH_2OP_MASK = 16'h0F0F,
  parameter logic [(1<<CMD_WIDTH)-1:0] LOGIC_2OP_MASK = 16'h003F,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [1:0]           INP_VALID,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic [WIDTH:0]       RES,
  input  logic                 COUT,
  input  logic                 OFLOW,
  input  logic                 G,
  input  logic                 L,
  input  logic                 E,
  input  logic                 ERR,
  output logic [3:0]           VIOL,
  output logic [CNT_WIDTH-1:0] VIOL_CNT,
  output logic [2:0]           FIRST_CODE,
  output logic                 PAIR_BUSY
);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_e;

  localparam int         OW       = WIDTH + 7;
  localparam logic [3:0] MASK_END = 4'(LATENCY + 1);
  localparam logic [3:0] LAT4     = 4'(LATENCY);
  localparam logic [7:0] TO8      = 8'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [7:0]             tcnt_q, tcnt_d;
  logic [3:0]             mcnt_q, zcnt_q;
  logic [LATENCY-1:0]     exp_to_q, exp_inv_q;
  logic                   push_to, push_inv;
  logic [OW-1:0]          snap_q, cur;
  logic [3:0]             viol_q, new_v;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [2:0]             code_q, code_new;
  logic                   need2, masked, armed;
  logic                   unused_opnd;

  assign unused_opnd = ^{OPA, OPB};
  assign need2  = MODE ? ARITH_2OP_MASK[CMD] : LOGIC_2OP_MASK[CMD];
  assign masked = (mcnt_q != MASK_END);
  assign armed  = !CE && (zcnt_q == LAT4);
  assign cur    = {RES, COUT, OFLOW, G, L, E, ERR};

  // Pairing FSM: only CE cycles advance it; a half in the timeout cycle still completes the pair.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    push_to  = 1'b0;
    push_inv = 1'b0;
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (INP_VALID == 2'b00) begin
            push_inv = 1'b1;
          end else if (need2 && INP_VALID == 2'b01) begin
            state_d = WAIT_B;
            tcnt_d  = 8'd1;
          end else if (need2 && INP_VALID == 2'b10) begin
            state_d = WAIT_A;
            tcnt_d  = 8'd1;
          end
        end
        WAIT_A, WAIT_B: begin
          if ((state_q == WAIT_A) ? INP_VALID[0] : INP_VALID[1]) begin
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
            if (tcnt_d == TO8) begin
              state_d = IDLE;
              push_to = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    new_v    = '0;
    new_v[0] = exp_to_q[LATENCY-1] && !ERR;
    new_v[1] = exp_inv_q[LATENCY-1] && !ERR;
    new_v[2] = armed && (cur != snap_q);
    new_v[3] = (G && L) || (G && E) || (L && E);
    if (masked) new_v = '0;
  end

  always_comb begin
    code_new = 3'd0;
    if      (new_v[0]) code_new = 3'd1;
    else if (new_v[1]) code_new = 3'd2;
    else if (new_v[2]) code_new = 3'd3;
    else if (new_v[3]) code_new = 3'd4;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      mcnt_q    <= '0;
      zcnt_q    <= '0;
      exp_to_q  <= '0;
      exp_inv_q <= '0;
      snap_q    <= '0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      snap_q       <= cur;
      exp_to_q[0]  <= push_to;
      exp_inv_q[0] <= push_inv;
      for (int i = 1; i < LATENCY; i++) begin
        exp_to_q[i]  <= exp_to_q[i-1];
        exp_inv_q[i] <= exp_inv_q[i-1];
      end
      if (masked) mcnt_q <= mcnt_q + 4'd1;
      if (CE)                  zcnt_q <= '0;
      else if (zcnt_q != LAT4) zcnt_q <= zcnt_q + 4'd1;
    end
  end

  // CLR beats a violation detected in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      viol_q <= '0;
      cnt_q  <= '0;
      code_q <= '0;
    end else if (CLR) begin
      viol_q <= '0;
      cnt_q  <= '0;
      code_q <= '0;
    end else if (new_v != 4'd0) begin
      viol_q <= viol_q | new_v;
      if (cnt_q != '1)      cnt_q  <= cnt_q + 1'b1;
      if (code_q == 3'd0)   code_q <= code_new;
    end
  end

  assign VIOL       = viol_q;
  assign VIOL_CNT   = cnt_q;
  assign FIRST_CODE = code_q;
  assign PAIR_BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_alu_protocol_monitor.sv
// Directed bench for alu_protocol_monitor with an event-level reference model.
module tb_alu_protocol_monitor;
  localparam int WIDTH = 8, CMD_WIDTH = 4, LATENCY = 1, TIMEOUT = 16, CNT_WIDTH = 8;

  logic CLK = 0, RST, CLR, CE, MODE, COUT, OFLOW, G, L, E, ERR;
  logic [CMD_WIDTH-1:0] CMD;
  logic [1:0] INP_VALID;
  logic [WIDTH-1:0] OPA, OPB;
  logic [WIDTH:0] RES;
  logic [3:0] VIOL;
  logic [CNT_WIDTH-1:0] VIOL_CNT;
  logic [2:0] FIRST_CODE;
  logic PAIR_BUSY;

  int ntests = 0, nfail = 0;

  alu_protocol_monitor #(
    .WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT),
    .ARITH_2OP_MASK(16'h0F0F), .LOGIC_2OP_MASK(16'h003F), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .CE(CE), .MODE(MODE), .CMD(CMD),
    .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .RES(RES), .COUT(COUT),
    .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR),
    .VIOL(VIOL), .VIOL_CNT(VIOL_CNT), .FIRST_CODE(FIRST_CODE), .PAIR_BUSY(PAIR_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reference model: pending half + CE-cycle timestamp, a due-cycle queue of ERR expectations,
  // and a CE history window for the hold rule.
  typedef struct { int due; int org; } exp_t;
  exp_t eq[$];
  bit   ce_hist[$];
  logic [15:0] a_mask = 16'h0F0F, l_mask = 16'h003F;
  logic [WIDTH+6:0] prev_out;
  int   cyc, since, have, start_ce, ce_total, m_cnt, m_code;
  logic [3:0] m_viol;
  bit   m_busy;

  always @(posedge CLK or negedge RST) begin : mdl
    logic [3:0] nv;
    logic [WIDTH+6:0] cur;
    bit need2, armed, miss;
    if (!RST) begin
      eq.delete(); ce_hist.delete();
      prev_out = '0; cyc = 0; since = 0; have = 0; start_ce = 0; ce_total = 0;
      m_cnt = 0; m_code = 0; m_viol = 0; m_busy = 0;
    end else begin
      nv  = 0;
      cur = {RES, COUT, OFLOW, G, L, E, ERR};
      for (int i = eq.size() - 1; i >= 0; i--)
        if (eq[i].due == cyc) begin
          if (ERR != 1'b1) nv[eq[i].org] = 1'b1;
          eq.delete(i);
        end
      armed = !CE && (ce_hist.size() == LATENCY);
      foreach (ce_hist[i]) if (ce_hist[i]) armed = 0;
      if (armed && cur != prev_out) nv[2] = 1'b1;
      if ($countones({G, L, E}) > 1) nv[3] = 1'b1;
      need2 = MODE ? a_mask[CMD] : l_mask[CMD];
      if (CE) begin
        if (have == 0) begin
          if (INP_VALID == 2'b00) eq.push_back('{cyc + LATENCY, 1});
          else if (need2 && INP_VALID == 2'b01) begin have = 1; start_ce = ce_total; end
          else if (need2 && INP_VALID == 2'b10) begin have = 2; start_ce = ce_total; end
        end else begin
          miss = (have == 1) ? INP_VALID[1] : INP_VALID[0];
          if (miss) have = 0;
          else if (ce_total - start_ce == TIMEOUT - 1) begin
            have = 0;
            eq.push_back('{cyc + LATENCY, 0});
          end
        end
        ce_total++;
      end
      if (since < LATENCY + 1) nv = 0;
      since++;
      ce_hist.push_back(CE);
      if (ce_hist.size() > LATENCY) void'(ce_hist.pop_front());
      prev_out = cur;
      cyc++;
      if (CLR) begin
        m_viol = 0; m_cnt = 0; m_code = 0;
      end else if (nv != 0) begin
        m_viol |= nv;
        if (m_cnt < 255) m_cnt++;
        if (m_code == 0) begin
          if (nv[0]) m_code = 1; else if (nv[1]) m_code = 2;
          else if (nv[2]) m_code = 3; else m_code = 4;
        end
      end
      m_busy = (have != 0);
    end
  end

  always @(negedge CLK) if (RST) begin
    chk("viol", VIOL, m_viol);
    chk("cnt", VIOL_CNT, m_cnt);
    chk("code", FIRST_CODE, m_code);
    chk("busy", PAIR_BUSY, m_busy);
  end

  task automatic pulse_clr();
    CLR = 1; tick(1); CLR = 0;
  endtask

  initial begin
    int busy_cycles;
    RST = 1; CLR = 0; CE = 1; MODE = 1; CMD = 0; INP_VALID = 2'b11;
    OPA = 8'h12; OPB = 8'h34; RES = 0; COUT = 0; OFLOW = 0; G = 0; L = 0; E = 0; ERR = 0;
    #1 RST = 0; #1;
    chk("rst_viol", VIOL, 0); chk("rst_cnt", VIOL_CNT, 0);
    chk("rst_code", FIRST_CODE, 0); chk("rst_busy", PAIR_BUSY, 0);
    @(negedge CLK); RST = 1; tick(3);

    // reset mid-pairing: abort with no violation
    INP_VALID = 2'b01; tick(9);
    chk("wait_busy", PAIR_BUSY, 1);
    #2 RST = 0; #1;
    chk("mid_rst_viol", VIOL, 0); chk("mid_rst_cnt", VIOL_CNT, 0);
    chk("mid_rst_code", FIRST_CODE, 0); chk("mid_rst_busy", PAIR_BUSY, 0);
    INP_VALID = 2'b11;
    @(negedge CLK); RST = 1; tick(2);
    chk("post_rst_viol", VIOL, 0); chk("post_rst_busy", PAIR_BUSY, 0);
    tick(2);

    // pairing completes after 5 cycles
    busy_cycles = 0;
    INP_VALID = 2'b01;
    for (int i = 0; i < 5; i++) begin tick(1); busy_cycles += PAIR_BUSY; end
    INP_VALID = 2'b10; OPB = 8'h55;
    tick(1); busy_cycles += PAIR_BUSY;
    INP_VALID = 2'b11;
    for (int i = 0; i < 3; i++) begin tick(1); busy_cycles += PAIR_BUSY; end
    chk("pair_busy_cycles", busy_cycles, 5);
    chk("pair_viol", VIOL, 0);

    // timeout with ERR missing
    INP_VALID = 2'b01; tick(16);
    INP_VALID = 2'b11; ERR = 0; tick(1);
    chk("to_viol", VIOL, 1); chk("to_cnt", VIOL_CNT, 1); chk("to_code", FIRST_CODE, 1);
    pulse_clr(); tick(1);
    chk("clr_viol", VIOL, 0); chk("clr_cnt", VIOL_CNT, 0); chk("clr_code", FIRST_CODE, 0);

    // timeout with ERR supplied
    INP_VALID = 2'b01; tick(16);
    INP_VALID = 2'b11; ERR = 1; tick(1);
    ERR = 0; tick(2);
    chk("to_err_ok", VIOL, 0);

    // invalid input: ERR supplied, then missing
    INP_VALID = 2'b00; tick(1);
    INP_VALID = 2'b11; ERR = 1; tick(1);
    ERR = 0; tick(1);
    chk("inv_err_ok", VIOL, 0);
    INP_VALID = 2'b00; tick(1);
    INP_VALID = 2'b11; tick(1);
    chk("inv_viol", VIOL, 2); chk("inv_code", FIRST_CODE, 2);
    pulse_clr(); tick(1);

    // logical command outside the 2-op mask needs no pairing
    MODE = 0; CMD = 4'd8; INP_VALID = 2'b01; tick(3);
    chk("1op_busy", PAIR_BUSY, 0);
    MODE = 1; CMD = 0; INP_VALID = 2'b11; tick(1);

    // hold: change in first disabled cycle is allowed
    CE = 0; RES = 9'h1A5; tick(1);
    tick(3);
    CE = 1; tick(2);
    chk("hold_ok", VIOL, 0);
    // hold: change in third disabled cycle is a violation
    CE = 0; tick(2);
    RES = 9'h05A; tick(1);
    tick(1);
    CE = 1; tick(1);
    chk("hold_viol", VIOL, 4); chk("hold_cnt", VIOL_CNT, 1); chk("hold_code", FIRST_CODE, 3);
    pulse_clr(); tick(1);

    // exclusivity + saturation
    G = 1; E = 1; tick(300);
    chk("sat_viol", VIOL, 8); chk("sat_cnt", VIOL_CNT, 255); chk("sat_code", FIRST_CODE, 4);
    CLR = 1; tick(1);
    chk("clrwin_viol", VIOL, 0); chk("clrwin_cnt", VIOL_CNT, 0); chk("clrwin_code", FIRST_CODE, 0);
    CLR = 0; G = 0; E = 0; tick(2);
    chk("final_viol", VIOL, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/alu_protocol_monitor.md
Name: alu_protocol_monitor

Overview:
- Synthesizable, parametrised runtime monitor for the ALU.
- Passively observes the ALU input bus (CE, MODE, CMD, INP_VALID, OPA/OPB) and the output bus (RES, COUT, OFLOW, G, L, E, ERR).
- Checks four protocol rules cycle by cycle: operand pairing with timeout, expected ERR after a fixed latency, output hold while disabled, and compare-flag exclusivity.
- Reports violations as sticky flags, a saturating counter and a first-violation code. It sits beside the ALU in both simulation and FPGA builds.

Parameters:
- WIDTH, 8, operand width; RES is WIDTH+1 bits.
- CMD_WIDTH, 4, command width.
- LATENCY, 1, cycles from an accepted input to the registered ALU output (1..8).
- TIMEOUT, 16, cycles allowed between the first and second operand halves (2..255).
- ARITH_2OP_MASK, 16'h0F0F, bit i = 1 means arithmetic CMD i needs both operands.
- LOGIC_2OP_MASK, 16'h003F, bit i = 1 means logical CMD i needs both operands.
- CNT_WIDTH, 8, width of the violation counter.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous clear of sticky flags, counter and code
- CE  in  1  ALU clock enable
- MODE  in  1  1 = arithmetic, 0 = logical
- CMD  in  CMD_WIDTH  ALU command
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- OPA, OPB  in  WIDTH  operands (observed only)
- RES  in  WIDTH+1  ALU result
- COUT, OFLOW, G, L, E, ERR  in  1 each  ALU flags
- VIOL  out  4  sticky flags: [0] timeout-ERR missing, [1] invalid-ERR missing, [2] hold broken, [3] G/L/E not exclusive
- VIOL_CNT  out  CNT_WIDTH  saturating violation count
- FIRST_CODE  out  3  0 = none; 1..4 = lowest-index VIOL bit of the first violating cycle
- PAIR_BUSY  out  1  monitor is waiting for the second operand half

Behaviour:
- Reset (RST = 0, asynchronous): VIOL = 0, VIOL_CNT = 0, FIRST_CODE = 0, PAIR_BUSY = 0, FSM = IDLE, pipelines and counters cleared.
  - All checks are masked for LATENCY+1 cycles after RST deasserts.
  - Reset asserted mid-pairing aborts the pairing with no violation.
- CLR has the same effect as reset on VIOL, VIOL_CNT and FIRST_CODE only. If CLR and a violation occur in the same cycle, CLR wins.
- Two-operand test: need2 = MODE ? ARITH_2OP_MASK[CMD] : LOGIC_2OP_MASK[CMD].
- Pairing FSM states: IDLE, WAIT_A, WAIT_B. Only cycles with CE = 1 advance the FSM; CE = 0 freezes the state and the timeout counter.
  - IDLE, need2 = 1, INP_VALID = 01: go to WAIT_B, tcnt = 1.
  - IDLE, need2 = 1, INP_VALID = 10: go to WAIT_A, tcnt = 1.
  - IDLE, INP_VALID = 11 or need2 = 0: no state change.
  - WAIT_x, the missing half arrives (INP_VALID = 11, or the missing bit alone): go to IDLE, no expectation pushed.
  - WAIT_x, tcnt reaches TIMEOUT without the missing half: go to IDLE and push expect_err. A half arriving in the timeout cycle itself still completes the pair.
  - WAIT_x, the same half repeats: tcnt keeps counting (no restart).
  - PAIR_BUSY = (state != IDLE).
- Invalid input: CE = 1 and INP_VALID = 00 in IDLE pushes expect_err.
- Expectation pipeline: a LATENCY-deep shift register that advances every cycle.
  - When a pushed bit emerges and ERR != 1, set VIOL[0] (timeout origin) or VIOL[1] (invalid origin); the origin travels with the bit.
- Hold check: armed once CE has been 0 for LATENCY consecutive cycles.
  - While armed, any change of {RES, COUT, OFLOW, G, L, E, ERR} from the previous cycle sets VIOL[2].
  - Disarmed in the first cycle with CE = 1.
- Exclusivity: outside the post-reset mask, more than one of G, L, E high in one cycle sets VIOL[3].
- Counting:
  - Each cycle with at least one new violation adds 1 to VIOL_CNT (at most one per cycle).
  - VIOL_CNT saturates at all-ones.
  - FIRST_CODE latches only while it is 0.
- All outputs are registered; a violation is visible on the cycle after its detection.

Test Plan:
- Reset: assert RST = 0 mid-WAIT_B with tcnt = 9 -> all outputs 0 and PAIR_BUSY = 0 immediately; release, wait 2 cycles -> VIOL = 0.
- Pairing pass: MODE = 1, CMD = 0 (ADD), INP_VALID = 01, then 10 after 5 cycles -> PAIR_BUSY high for 5 cycles, VIOL = 0 with ERR = 0 throughout.
- Timeout: INP_VALID = 01 held for 16 cycles, ALU ERR kept 0 -> VIOL = 4'b0001, VIOL_CNT = 1, FIRST_CODE = 1. Repeat with ERR = 1 at the expected cycle -> no violation.
- Hold: CE = 0 for 4 cycles, RES toggles in cycle 3 -> VIOL[2] = 1. RES toggling only in cycle 1 (LATENCY = 1 window) -> no violation.
- Flags and saturation: force G = E = 1 for 300 cycles with CNT_WIDTH = 8 -> VIOL_CNT = 255, FIRST_CODE = 4. Pulse CLR -> all cleared next cycle.
